// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite loopback pair: master FSM states and response codes.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    COMPARE
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_lite_reg_slave.sv
// Four-register AXI4-Lite slave; registers decoded from ADDR[3:2], one transaction per channel.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [3:0]              araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [1:0]            aw_sel, ar_sel;
  logic [DATA_WIDTH-1:0] wr_old, wr_val, rd_val;
  logic                  wr_en, unused_addr;

  assign bresp       = RESP_OKAY;
  assign rresp       = RESP_OKAY;
  assign wr_en       = awready & awvalid & wready & wvalid;
  assign unused_addr = ^{awaddr[1:0], araddr[1:0]};

  // Byte-strobe merge onto the currently addressed register.
  always_comb begin
    wr_old = '0;
    case (aw_sel)
      2'd0: wr_old = slv_reg0;
      2'd1: wr_old = slv_reg1;
      2'd2: wr_old = slv_reg2;
      2'd3: wr_old = slv_reg3;
      default: wr_old = '0;
    endcase
    wr_val = wr_old;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (wstrb[b]) wr_val[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  always_comb begin
    rd_val = '0;
    case (ar_sel)
      2'd0: rd_val = slv_reg0;
      2'd1: rd_val = slv_reg1;
      2'd2: rd_val = slv_reg2;
      2'd3: rd_val = slv_reg3;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      aw_sel   <= '0;
      slv_reg0 <= '0;
      slv_reg1 <= '0;
      slv_reg2 <= '0;
      slv_reg3 <= '0;
    end else begin
      awready <= awvalid & wvalid & ~awready & ~bvalid;
      wready  <= awvalid & wvalid & ~awready & ~bvalid;
      if (awvalid & wvalid & ~awready & ~bvalid) aw_sel <= awaddr[3:2];
      if (wr_en) begin
        case (aw_sel)
          2'd0: slv_reg0 <= wr_val;
          2'd1: slv_reg1 <= wr_val;
          2'd2: slv_reg2 <= wr_val;
          2'd3: slv_reg3 <= wr_val;
          default: ;
        endcase
      end
      if (wr_en && !bvalid) bvalid <= 1'b1;
      else if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      ar_sel  <= '0;
    end else begin
      arready <= arvalid & ~arready & ~rvalid;
      if (arvalid & ~arready & ~rvalid) ar_sel <= araddr[3:2];
      if (arready && arvalid && !rvalid) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_lite_loopback.sv
// AXI4-Lite memory-test master joined to a 4-register slave: writes N words, reads them back, flags errors.
module axi_lite_loopback
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] C_M_START_DATA_VALUE       = 32'hAA000000,
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
  parameter int unsigned C_AXI_ADDR_WIDTH           = 32,
  parameter int unsigned C_AXI_DATA_WIDTH           = 32,
  parameter int unsigned C_M_TRANSACTIONS_NUM       = 4
) (
  input  logic i_axi_clk,
  input  logic i_axi_rst_n,
  input  logic i_axi_init_txn,
  output logic o_txn_done,
  output logic o_error,
  output logic o_busy
);

  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr, axi_araddr;
  logic [2:0]                    axi_awprot, axi_arprot;
  logic                          axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata, axi_rdata;
  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb;
  logic [1:0]                    axi_bresp, axi_rresp;
  logic                          axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic                          axi_rvalid, axi_rready;

  state_t                      state, state_next;
  logic [2:0]                  idx;
  logic                        init_d1, init_d2, start;
  logic                        wr_pending, rd_pending, b_done, r_done, last;
  logic [C_AXI_DATA_WIDTH-1:0] exp_data;
  logic                        unused_bus;

  assign start      = init_d1 & ~init_d2;
  assign b_done     = axi_bvalid & axi_bready;
  assign r_done     = axi_rvalid & axi_rready;
  assign last       = (idx == 3'(C_M_TRANSACTIONS_NUM - 1));
  assign exp_data   = C_M_START_DATA_VALUE + C_AXI_DATA_WIDTH'(idx);
  assign axi_awaddr = C_M_TARGET_SLAVE_BASE_ADDR + C_AXI_ADDR_WIDTH'({idx, 2'b00});
  assign axi_araddr = axi_awaddr;
  assign axi_wdata  = exp_data;
  assign axi_wstrb  = '1;
  assign axi_awprot = 3'b000;
  assign axi_arprot = 3'b000;
  assign unused_bus = ^{axi_awaddr[C_AXI_ADDR_WIDTH-1:4], axi_araddr[C_AXI_ADDR_WIDTH-1:4],
                        axi_awprot, axi_arprot};

  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = WRITE;
      WRITE:   if (b_done && last) state_next = READ;
      READ:    if (r_done && last) state_next = COMPARE;
      COMPARE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each phase issues one transaction at a time; the pending flag gates re-issue until the response handshake.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      init_d1     <= 1'b0;
      init_d2     <= 1'b0;
      idx         <= '0;
      wr_pending  <= 1'b0;
      rd_pending  <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      o_txn_done  <= 1'b0;
      o_error     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      init_d1 <= i_axi_init_txn;
      init_d2 <= init_d1;
      case (state)
        IDLE: begin
          if (start) begin
            o_txn_done <= 1'b0;
            o_error    <= 1'b0;
            o_busy     <= 1'b1;
            idx        <= '0;
          end
        end
        WRITE: begin
          if (!wr_pending) begin
            axi_awvalid <= 1'b1;
            axi_wvalid  <= 1'b1;
            axi_bready  <= 1'b1;
            wr_pending  <= 1'b1;
          end
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
          if (b_done) begin
            axi_bready <= 1'b0;
            wr_pending <= 1'b0;
            if (axi_bresp[1]) o_error <= 1'b1;
            idx <= last ? '0 : idx + 3'd1;
          end
        end
        READ: begin
          if (!rd_pending) begin
            axi_arvalid <= 1'b1;
            axi_rready  <= 1'b1;
            rd_pending  <= 1'b1;
          end
          if (axi_arvalid && axi_arready) axi_arvalid <= 1'b0;
          if (r_done) begin
            axi_rready <= 1'b0;
            rd_pending <= 1'b0;
            if (axi_rresp[1] || (axi_rdata != exp_data)) o_error <= 1'b1;
            idx <= last ? '0 : idx + 3'd1;
          end
        end
        COMPARE: begin
          o_txn_done <= 1'b1;
          o_busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  axi_lite_reg_slave #(
    .DATA_WIDTH (C_AXI_DATA_WIDTH)
  ) u_slave (
    .clk     (i_axi_clk),
    .rst_n   (i_axi_rst_n),
    .awaddr  (axi_awaddr[3:0]),
    .awvalid (axi_awvalid),
    .awready (axi_awready),
    .wdata   (axi_wdata),
    .wstrb   (axi_wstrb),
    .wvalid  (axi_wvalid),
    .wready  (axi_wready),
    .bresp   (axi_bresp),
    .bvalid  (axi_bvalid),
    .bready  (axi_bready),
    .araddr  (axi_araddr[3:0]),
    .arvalid (axi_arvalid),
    .arready (axi_arready),
    .rdata   (axi_rdata),
    .rresp   (axi_rresp),
    .rvalid  (axi_rvalid),
    .rready  (axi_rready)
  );

endmodule

// File: tb/tb_axi_lite_loopback.sv
// Directed bench for axi_lite_loopback: table-checked register/address results plus error, rerun and reset sequences.
`timescale 1ps/1ps
module tb_axi_lite_loopback;
  import axi_lite_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic done, error, busy;
  logic done1, error1, busy1;

  int total = 0;
  int bad = 0;

  axi_lite_loopback dut (
    .i_axi_clk      (clk),
    .i_axi_rst_n    (rst_n),
    .i_axi_init_txn (init),
    .o_txn_done     (done),
    .o_error        (error),
    .o_busy         (busy)
  );

  axi_lite_loopback #(
    .C_M_TRANSACTIONS_NUM (1)
  ) dut1 (
    .i_axi_clk      (clk),
    .i_axi_rst_n    (rst_n),
    .i_axi_init_txn (init),
    .o_txn_done     (done1),
    .o_error        (error1),
    .o_busy         (busy1)
  );

  always #5 clk = ~clk;

  // Bus monitors, sampled on the falling edge.
  logic [31:0] awlog [0:15];
  int aw_count = 0;
  int aw_count1 = 0;
  int viol = 0;
  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.axi_awvalid && dut.axi_awready) begin
        if (aw_count < 16) awlog[aw_count] = dut.axi_awaddr;
        aw_count++;
      end
      if (dut1.axi_awvalid && dut1.axi_awready) aw_count1++;
      if (p_awv && !p_awr && !dut.axi_awvalid) viol++;
      if (p_wv && !p_wr && !dut.axi_wvalid) viol++;
      if (p_arv && !p_arr && !dut.axi_arvalid) viol++;
    end
    p_awv = dut.axi_awvalid; p_awr = dut.axi_awready;
    p_wv  = dut.axi_wvalid;  p_wr  = dut.axi_wready;
    p_arv = dut.axi_arvalid; p_arr = dut.axi_arready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_reg(input int i);
    case (i)
      0: return dut.u_slave.slv_reg0;
      1: return dut.u_slave.slv_reg1;
      2: return dut.u_slave.slv_reg2;
      default: return dut.u_slave.slv_reg3;
    endcase
  endfunction

  function automatic logic [31:0] get_reg1(input int i);
    case (i)
      0: return dut1.u_slave.slv_reg0;
      1: return dut1.u_slave.slv_reg1;
      2: return dut1.u_slave.slv_reg2;
      default: return dut1.u_slave.slv_reg3;
    endcase
  endfunction

  task automatic wait_done();
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_read();
    for (int i = 0; i < 100 && dut.state != READ; i++) @(negedge clk);
    check("read_phase_timeout", {30'b0, dut.state}, {30'b0, READ});
  endtask

  // Re-arm init and confirm done clears within three cycles of the new edge.
  task automatic start_run();
    init = 1'b0;
    repeat (3) @(negedge clk);
    init = 1'b1;
    for (int i = 0; i < 3 && done; i++) @(negedge clk);
    check("done_drop", {31'b0, done}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] exp_reg;
    logic [31:0] exp_addr;
    logic [31:0] exp_reg_n1;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int t0;
    tbl[0] = '{32'hAA000000, 32'h40000000, 32'hAA000000};
    tbl[1] = '{32'hAA000001, 32'h40000004, 32'h00000000};
    tbl[2] = '{32'hAA000002, 32'h40000008, 32'h00000000};
    tbl[3] = '{32'hAA000003, 32'h4000000C, 32'h00000000};

    #50;
    check("rst_done",  {31'b0, done},  32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_busy",  {31'b0, busy},  32'd0);
    check("rst_awvalid", {31'b0, dut.axi_awvalid}, 32'd0);
    check("rst_reg3", get_reg(3), 32'd0);
    #50 rst_n = 1'b1;
    #900 init = 1'b1;

    // Run 1: level held high, exactly one run expected.
    t0 = 0;
    while (!busy && t0 < 10) begin @(negedge clk); t0++; end
    t0 = 0;
    while (!done && t0 < 100) begin @(negedge clk); t0++; end
    check("done_timeout", {31'b0, done}, 32'd1);
    check("run1_latency_le40", {31'b0, t0 <= 40}, 32'd1);
    repeat (20) @(negedge clk);
    check("run1_done",  {31'b0, done},  32'd1);
    check("run1_error", {31'b0, error}, 32'd0);
    check("run1_busy",  {31'b0, busy},  32'd0);
    check("run1_aw_count", aw_count, 32'd4);
    check("handshake_viol", viol, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reg%0d", i), get_reg(i), tbl[i].exp_reg);
      check($sformatf("awaddr%0d", i), awlog[i], tbl[i].exp_addr);
      check($sformatf("n1_reg%0d", i), get_reg1(i), tbl[i].exp_reg_n1);
    end
    check("n1_aw_count", aw_count1, 32'd1);
    check("n1_done",  {31'b0, done1},  32'd1);
    check("n1_error", {31'b0, error1}, 32'd0);

    // Corrupt reg 2 between write and read phases.
    start_run();
    wait_read();
    force dut.u_slave.slv_reg2 = 32'h0;
    wait_done();
    check("corrupt_error", {31'b0, error}, 32'd1);
    release dut.u_slave.slv_reg2;

    // Clean rerun after an errored run.
    start_run();
    wait_done();
    check("rerun_error", {31'b0, error}, 32'd0);
    check("rerun_reg2", get_reg(2), 32'hAA000002);

    // Reset in the middle of the read phase.
    start_run();
    wait_read();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_done",    {31'b0, done},  32'd0);
    check("midrst_error",   {31'b0, error}, 32'd0);
    check("midrst_busy",    {31'b0, busy},  32'd0);
    check("midrst_valids",  {28'b0, dut.axi_awvalid, dut.axi_wvalid, dut.axi_arvalid, dut.u_slave.rvalid}, 32'd0);
    check("midrst_readies", {30'b0, dut.axi_bready, dut.axi_rready}, 32'd0);
    init = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_run();
    wait_done();
    check("postrst_error", {31'b0, error}, 32'd0);
    check("postrst_reg3", get_reg(3), 32'hAA000003);
    check("handshake_viol_end", viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
